mult_div_ctrl: RTL
==================

Name: mult_div_ctrl

Overview:
- Multicycle sequencer for signed MULT and DIV; owns the Hi and Lo registers that feed mux_writeData.
- Started by a one-cycle request from unid_control; operands come from the A and B register outputs.
- Runs a 32-step radix-2 Booth multiply or a restoring divide, then returns a one-cycle done pulse so the control unit can leave its wait state.

Parameters:
- WIDTH, 32, operand width; Hi and Lo are WIDTH bits each; iteration count = WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; clears all state and outputs.
- start_mult  in  1  request a signed multiply of a_in by b_in.
- start_div  in  1  request a signed divide of a_in by b_in.
- a_in  in  WIDTH  operand A (multiplicand / dividend), sampled on the accepting edge only.
- b_in  in  WIDTH  operand B (multiplier / divisor), sampled on the accepting edge only.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  one-cycle pulse, high exactly while in DONE.
- div_zero  out  1  set when a divide with b_in==0 is accepted.
- Hi_out  out  WIDTH  Hi register (MULT: product[63:32]; DIV: remainder).
- Lo_out  out  WIDTH  Lo register (MULT: product[31:0]; DIV: quotient).

Behaviour:
- Reset values: state=IDLE, busy=0, done=0, div_zero=0, Hi_out=0, Lo_out=0, counter=0. Reset mid-operation aborts the operation with no partial Hi/Lo update.
- States: IDLE, MULT, DIV, DIV_FIX, DONE.
- Starts are accepted only in IDLE. A start in any other state is ignored and not queued.
- Accepting edge (E0):
  - Latch a_in and b_in, clear counter, clear div_zero.
  - start_mult has priority when both starts are high; start_div is dropped.
- MULT:
  - Each edge performs one Booth step on {acc, multiplier, q-1}: add or subtract the multiplicand per the (q0, q-1) pair, then arithmetic shift right, and increment counter.
  - At counter==WIDTH-1 (edge E32), load Hi/Lo with the 64-bit signed product and go to DONE.
  - done is high in the cycle after E32, so latency is 33 cycles from the accepting edge.
- DIV:
  - If b_in==0 at E0, go directly to DONE with div_zero=1 and Hi/Lo unchanged; done is high in the cycle after E0.
  - Otherwise operate on magnitudes |a| and |b|. Each edge shifts the remainder/quotient pair left one bit, trial-subtracts |b|, and restores if the result is negative.
  - After WIDTH steps (edge E32) go to DIV_FIX.
- DIV_FIX, one edge (E33):
  - Lo = quotient, negated if sign(a) differs from sign(b), i.e. truncation toward zero.
  - Hi = remainder, negated if a<0, i.e. the remainder takes the sign of the dividend.
  - Go to DONE. Divide latency is 34 cycles.
- Overflow case 0x80000000 / 0xFFFFFFFF: Lo=0x80000000, Hi=0, div_zero=0, no trap.
- DONE lasts exactly one cycle, then IDLE. A start asserted during DONE is ignored.
- div_zero is sticky until the next accepted start or reset.
- Hi_out and Lo_out change only on the final load edge; they hold between operations and stay stable while busy.
- All arithmetic is two's complement with WIDTH-bit wrap. Internal accumulators are WIDTH+1 bits to hold the subtract sign.

Test Plan:
- MULT 7 x 0xFFFFFFFD (-3): done high 33 cycles after the start edge; Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; busy high for 32 cycles.
- MULT 0x80000000 x 0x80000000: Hi=0x40000000, Lo=0x00000000. MULT 0x7FFFFFFF x 0x7FFFFFFF: Hi=0x3FFFFFFF, Lo=0x00000001.
- DIV 0xFFFFFFF9 (-7) / 2: done at cycle 34; Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF: Lo=0x80000000, Hi=0.
- Preload Hi/Lo via MULT 3x5 (Hi=0, Lo=15), then DIV 5/0: done in the next cycle, div_zero=1, Hi=0, Lo=15; a following MULT clears div_zero on its accepting edge.
- start_div pulsed at cycle 10 of a MULT is ignored and the MULT result is correct; start_mult and start_div high together perform MULT; a start during DONE is ignored.
- Reset at cycle 12 of DIV 100/7: the next cycle shows busy=0, done=0, Hi=Lo=0; a fresh DIV 100/7 then gives Lo=14, Hi=2.

Source files
------------

// File: rtl/mult_div_ctrl.sv
// mult_div_ctrl: multicycle signed MULT/DIV sequencer that owns the Hi/Lo
// registers. MULT runs WIDTH radix-2 Booth steps; DIV runs WIDTH restoring
// steps on operand magnitudes followed by a single sign-fix step. A one-cycle
// done pulse tells the control unit it can leave its wait state.
module mult_div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] Hi_out,
    output logic [WIDTH-1:0] Lo_out
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]    CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0]    CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    LAST_STEP = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] W_ZERO    = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] W_ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH:0]   W1_ZERO   = {(WIDTH+1){1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MULT    = 3'd1,
        ST_DIV     = 3'd2,
        ST_DIV_FIX = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Two's complement negation with WIDTH-bit wrap.
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        negate = ~v + W_ONE;
    endfunction

    // Magnitude of a signed value; the most negative value maps to itself,
    // which reads correctly as an unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        if (v[WIDTH-1]) begin
            magnitude = negate(v);
        end else begin
            magnitude = v;
        end
    endfunction

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // Booth datapath: {acc, multiplier, q-1}; acc has one guard bit so that
    // subtracting the most negative multiplicand cannot overflow.
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic             qm1_q, qm1_d;
    // Restoring divide datapath on magnitudes.
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    // Architectural outputs.
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH:0]   mcand_ext_s;
    logic [WIDTH:0]   booth_sum_s;
    logic [WIDTH:0]   booth_acc_s;
    logic [WIDTH-1:0] booth_mq_s;
    logic             booth_qm1_s;

    logic [WIDTH:0]   rem_sh_s;
    logic [WIDTH-1:0] quo_sh_s;
    logic [WIDTH:0]   trial_s;
    logic [WIDTH-1:0] rem_step_s;
    logic [WIDTH-1:0] quo_step_s;

    // One Booth step: add/subtract multiplicand per (q0, q-1), then arithmetic shift right.
    always_comb begin
        mcand_ext_s = {mcand_q[WIDTH-1], mcand_q};
        case ({mq_q[0], qm1_q})
            2'b01:   booth_sum_s = acc_q + mcand_ext_s;
            2'b10:   booth_sum_s = acc_q - mcand_ext_s;
            default: booth_sum_s = acc_q;
        endcase
        booth_acc_s = {booth_sum_s[WIDTH], booth_sum_s[WIDTH:1]};
        booth_mq_s  = {booth_sum_s[0], mq_q[WIDTH-1:1]};
        booth_qm1_s = mq_q[0];
    end

    // One restoring divide step: shift {rem, quo} left, trial-subtract divisor, keep or restore.
    always_comb begin
        rem_sh_s = {rem_q, quo_q[WIDTH-1]};
        quo_sh_s = {quo_q[WIDTH-2:0], 1'b0};
        trial_s  = rem_sh_s - {1'b0, dvsr_q};
        if (trial_s[WIDTH]) begin
            rem_step_s = rem_sh_s[WIDTH-1:0];
            quo_step_s = quo_sh_s;
        end else begin
            rem_step_s = trial_s[WIDTH-1:0];
            quo_step_s = quo_sh_s | W_ONE;
        end
    end

    // Next-state and datapath update for the sequencer.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        qm1_d     = qm1_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            ST_IDLE: begin
                if (start_mult) begin
                    // MULT wins when both requests arrive together.
                    state_d = ST_MULT;
                    cnt_d   = CNT_ZERO;
                    dz_d    = 1'b0;
                    mcand_d = a_in;
                    acc_d   = W1_ZERO;
                    mq_d    = b_in;
                    qm1_d   = 1'b0;
                end else if (start_div) begin
                    cnt_d = CNT_ZERO;
                    if (b_in == W_ZERO) begin
                        // Divide by zero: finish immediately, Hi/Lo untouched.
                        state_d = ST_DONE;
                        dz_d    = 1'b1;
                    end else begin
                        state_d   = ST_DIV;
                        dz_d      = 1'b0;
                        rem_d     = W_ZERO;
                        quo_d     = magnitude(a_in);
                        dvsr_d    = magnitude(b_in);
                        neg_quo_d = a_in[WIDTH-1] ^ b_in[WIDTH-1];
                        neg_rem_d = a_in[WIDTH-1];
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MULT: begin
                acc_d = booth_acc_s;
                mq_d  = booth_mq_s;
                qm1_d = booth_qm1_s;
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == LAST_STEP) begin
                    hi_d    = booth_acc_s[WIDTH-1:0];
                    lo_d    = booth_mq_s;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_MULT;
                end
            end
            ST_DIV: begin
                rem_d = rem_step_s;
                quo_d = quo_step_s;
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == LAST_STEP) begin
                    state_d = ST_DIV_FIX;
                end else begin
                    state_d = ST_DIV;
                end
            end
            ST_DIV_FIX: begin
                // Quotient truncates toward zero; remainder follows the dividend sign.
                if (neg_quo_q) begin
                    lo_d = negate(quo_q);
                end else begin
                    lo_d = quo_q;
                end
                if (neg_rem_q) begin
                    hi_d = negate(rem_q);
                end else begin
                    hi_d = rem_q;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_MULT) || (state_d == ST_DIV) || (state_d == ST_DIV_FIX);
        done_d = (state_d == ST_DONE);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= CNT_ZERO;
            mcand_q   <= W_ZERO;
            acc_q     <= W1_ZERO;
            mq_q      <= W_ZERO;
            qm1_q     <= 1'b0;
            rem_q     <= W_ZERO;
            quo_q     <= W_ZERO;
            dvsr_q    <= W_ZERO;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= W_ZERO;
            lo_q      <= W_ZERO;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            qm1_q     <= qm1_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;
    assign Hi_out   = hi_q;
    assign Lo_out   = lo_q;

endmodule
